// File: rtl/shift_test_pkg.sv
// Shared encodings and default sizing for the shift-chain SET test controller.
package shift_test_pkg;

  localparam int DEF_NUM_CHAINS  = 2;
  localparam int DEF_CHAIN_LEN   = 64;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 12;
  localparam int DEF_RUN_W       = 16;

  typedef enum logic [1:0] {
    MODE_ONES  = 2'b00,
    MODE_ZEROS = 2'b01,
    MODE_ALT   = 2'b10,
    MODE_RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_FILL    = 2'b01,
    ST_COMPARE = 2'b10,
    ST_DONE    = 2'b11
  } state_e;

  // Reserved mode falls through to all-ones.
  function automatic logic pat_bit(input mode_e m, input logic p);
    logic b;
    b = 1'b1;
    case (m)
      MODE_ZEROS: b = 1'b0;
      MODE_ALT:   b = p;
      default:    b = 1'b1;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/shift_err_chan.sv
// Per-chain checker: synchronise the returned serial bit, compare, count, flag.
module shift_err_chan
  import shift_test_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             clr,
  input  logic             en,
  input  logic             expected,
  input  logic             shift_out,
  output logic             err_flag,
  output logic [CNT_W-1:0] err_cnt
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   mismatch;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], shift_out};
  end

  assign mismatch = en && (sync_q[SYNC_STAGES-1] != expected);

  // Counter sticks at all-ones rather than wrapping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (clr) begin
      err_cnt  <= '0;
      err_flag <= 1'b0;
    end else if (mismatch) begin
      err_flag <= 1'b1;
      if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/shift_chain_test_ctrl.sv
// SET-characterisation sequencer: fill the DUT chains with a pattern, then
// compare the returned bits for RUN_LEN cycles with one checker per chain.
module shift_chain_test_ctrl
  import shift_test_pkg::*;
#(
  parameter int NUM_CHAINS  = DEF_NUM_CHAINS,
  parameter int CHAIN_LEN   = DEF_CHAIN_LEN,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int RUN_W       = DEF_RUN_W
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        START,
  input  logic                        STOP,
  input  logic [1:0]                  MODE,
  input  logic [RUN_W-1:0]            RUN_LEN,
  output logic                        SHIFT_EN,
  output logic [NUM_CHAINS-1:0]       SHIFT_INPUT,
  input  logic [NUM_CHAINS-1:0]       SHIFT_OUT,
  output logic                        BUSY,
  output logic                        DONE,
  output logic [NUM_CHAINS-1:0]       ERR_FLAG,
  output logic [NUM_CHAINS*CNT_W-1:0] ERR_CNT
);

  localparam int   FILL_LEN = CHAIN_LEN + SYNC_STAGES;
  localparam int   FILL_W   = $clog2(FILL_LEN + 1);
  // Odd round-trip latency inverts the alternating phase seen at compare time.
  localparam logic EXP_INV  = logic'(FILL_LEN % 2);

  state_e                              state_q, state_d;
  mode_e                               mode_q;
  logic [RUN_W-1:0]                    run_len_q, run_cnt_q;
  logic [FILL_W-1:0]                   fill_cnt_q;
  logic                                phase_q;
  logic                                start_ok, fill_last, run_last;
  logic                                shift_en, cmp_en;
  logic                                pat, exp_bit;
  logic [NUM_CHAINS-1:0][CNT_W-1:0]    err_cnt_a;

  assign start_ok  = (state_q == ST_IDLE) && START;
  assign fill_last = (fill_cnt_q == FILL_W'(FILL_LEN - 1));
  assign run_last  = (run_len_q != '0) && (run_cnt_q == run_len_q - RUN_W'(1));

  always_comb begin
    state_d  = state_q;
    shift_en = 1'b0;
    cmp_en   = 1'b0;
    BUSY     = 1'b1;
    DONE     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        BUSY = 1'b0;
        if (START) state_d = ST_FILL;
      end
      ST_FILL: begin
        shift_en = 1'b1;
        if (STOP)           state_d = ST_IDLE;
        else if (fill_last) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        shift_en = 1'b1;
        cmp_en   = 1'b1;
        if (STOP)          state_d = ST_IDLE;
        else if (run_last) state_d = ST_DONE;
      end
      ST_DONE: begin
        DONE    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_ONES;
      run_len_q  <= '0;
      run_cnt_q  <= '0;
      fill_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        mode_q    <= mode_e'(MODE);
        run_len_q <= RUN_LEN;
      end
      fill_cnt_q <= (state_q == ST_FILL)    ? fill_cnt_q + FILL_W'(1) : '0;
      run_cnt_q  <= (state_q == ST_COMPARE) ? run_cnt_q + RUN_W'(1)   : '0;
      if (start_ok)      phase_q <= 1'b1;
      else if (shift_en) phase_q <= ~phase_q;
    end
  end

  assign pat         = pat_bit(mode_q, phase_q);
  assign exp_bit     = pat_bit(mode_q, phase_q ^ EXP_INV);
  assign SHIFT_EN    = shift_en;
  assign SHIFT_INPUT = shift_en ? {NUM_CHAINS{pat}} : '0;

  for (genvar i = 0; i < NUM_CHAINS; i++) begin : g_chan
    shift_err_chan #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W)
    ) u_chan (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .clr       (start_ok),
      .en        (cmp_en),
      .expected  (exp_bit),
      .shift_out (SHIFT_OUT[i]),
      .err_flag  (ERR_FLAG[i]),
      .err_cnt   (err_cnt_a[i])
    );
  end

  assign ERR_CNT = err_cnt_a;

endmodule

// File: tb/tb_shift_chain_test_ctrl.sv
// Directed bench: ideal/faulted chain models around two controllers (CNT_W 12 and 4).
module tb_shift_chain_test_ctrl;

  localparam int NC  = 2;
  localparam int CL  = 64;
  localparam int CW  = 12;
  localparam int CWB = 4;
  localparam int RW  = 16;

  logic              CLK = 1'b0, RST_N = 1'b0, START = 1'b0, STOP = 1'b0;
  logic [1:0]        MODE = 2'b00;
  logic [RW-1:0]     RUN_LEN = '0;
  logic              shift_en, shift_en_b, busy, busy_b, done, done_b;
  logic [NC-1:0]     shift_in, shift_in_b, shift_out, err_flag, err_flag_b;
  logic [NC*CW-1:0]  err_cnt;
  logic [NC*CWB-1:0] err_cnt_b;

  logic [NC-1:0][CL-1:0] chain = '0;
  logic [NC-1:0]         flt_en = '0, flt_val = '0;
  int checks = 0, fails = 0, cyc = 0, done_cnt = 0, at = 0, d0 = 0;

  always #5 CLK = ~CLK;

  shift_chain_test_ctrl #(.CNT_W(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE(MODE), .RUN_LEN(RUN_LEN),
    .SHIFT_EN(shift_en), .SHIFT_INPUT(shift_in), .SHIFT_OUT(shift_out),
    .BUSY(busy), .DONE(done), .ERR_FLAG(err_flag), .ERR_CNT(err_cnt));

  shift_chain_test_ctrl #(.CNT_W(CWB)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .MODE(MODE), .RUN_LEN(RUN_LEN),
    .SHIFT_EN(shift_en_b), .SHIFT_INPUT(shift_in_b), .SHIFT_OUT(shift_out),
    .BUSY(busy_b), .DONE(done_b), .ERR_FLAG(err_flag_b), .ERR_CNT(err_cnt_b));

  // Ideal CHAIN_LEN-deep chains with per-chain stuck-at override on the output.
  always @(posedge CLK)
    if (shift_en)
      for (int i = 0; i < NC; i++) chain[i] <= {chain[i][CL-2:0], shift_in[i]};

  always_comb
    for (int i = 0; i < NC; i++) shift_out[i] = flt_en[i] ? flt_val[i] : chain[i][CL-1];

  always @(posedge CLK) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    cyc++;
  endtask

  task automatic go(input logic [1:0] m, input logic [RW-1:0] n);
    @(negedge CLK);
    MODE = m; RUN_LEN = n; START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    cyc = 1;
  endtask

  task automatic wait_done(output int when);
    when = -1;
    while (cyc < 600) begin
      if (done) begin when = cyc; break; end
      tick();
    end
  endtask

  initial begin
    #12;
    chk("rst_shift_en", shift_en, 0);
    chk("rst_shift_in", shift_in, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flag", err_flag, 0);
    chk("rst_cnt", err_cnt, 0);
    @(negedge CLK) RST_N = 1'b1;

    // 1: all-ones, clean chains
    go(2'b00, 16'd100);
    chk("t1_busy", busy, 1);
    chk("t1_shift_en", shift_en, 1);
    chk("t1_shift_in", shift_in, 2'b11);
    wait_done(at);
    chk("t1_done_cyc", at, 167);
    chk("t1_done_b", done_b, 1);
    chk("t1_cnt", err_cnt, 0);
    chk("t1_flag", err_flag, 0);
    tick();
    chk("t1_done_pulse", done, 0);
    chk("t1_idle_busy", busy, 0);
    chk("t1_idle_shift_en", shift_en, 0);

    // 2: chain0 glitched low for 3 cycles mid-compare
    go(2'b00, 16'd100);
    while (cyc < 100) tick();
    flt_en = 2'b01; flt_val = 2'b00;
    repeat (3) tick();
    flt_en = 2'b00;
    wait_done(at);
    chk("t2_done_cyc", at, 167);
    chk("t2_cnt0", err_cnt[CW-1:0], 3);
    chk("t2_cnt1", err_cnt[2*CW-1:CW], 0);
    chk("t2_flag", err_flag, 2'b01);

    // 3: alternating, chain1 stuck-at-0
    flt_en = 2'b10; flt_val = 2'b00;
    go(2'b10, 16'd100);
    chk("t3_pat_c1", shift_in, 2'b11);
    tick();
    chk("t3_pat_c2", shift_in, 2'b00);
    wait_done(at);
    chk("t3_cnt0", err_cnt[CW-1:0], 0);
    chk("t3_cnt1", err_cnt[2*CW-1:CW], 50);
    chk("t3_flag", err_flag, 2'b10);
    chk("t3_cnt1_b_sat", err_cnt_b[2*CWB-1:CWB], 15);
    repeat (3) tick();
    chk("t3_cnt1_hold", err_cnt[2*CW-1:CW], 50);

    // 4: all-zeros, chain0 stuck-at-1; 4-bit counter saturates
    flt_en = 2'b01; flt_val = 2'b01;
    go(2'b01, 16'd100);
    chk("t4_pat", shift_in, 2'b00);
    wait_done(at);
    chk("t4_cnt0", err_cnt[CW-1:0], 100);
    chk("t4_cnt0_b", err_cnt_b[CWB-1:0], 15);
    chk("t4_cnt1_b_cleared", err_cnt_b[2*CWB-1:CWB], 0);
    chk("t4_flag_b", err_flag_b, 2'b01);
    flt_en = 2'b00;

    // 5: STOP at compare cycle 10 after 5 mismatches
    flt_en = 2'b01; flt_val = 2'b00;
    go(2'b00, 16'd100);
    d0 = done_cnt;
    while (cyc < 70) tick();
    flt_en = 2'b00;
    while (cyc < 76) tick();
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("t5_busy", busy, 0);
    chk("t5_shift_en", shift_en, 0);
    chk("t5_cnt0", err_cnt[CW-1:0], 5);
    chk("t5_flag", err_flag, 2'b01);
    repeat (120) tick();
    chk("t5_no_done", done_cnt - d0, 0);
    chk("t5_cnt0_hold", err_cnt[CW-1:0], 5);
    go(2'b00, 16'd100);
    chk("t5_clr_cnt", err_cnt, 0);
    chk("t5_clr_flag", err_flag, 0);
    wait_done(at);
    chk("t5_rerun_done", at, 167);

    // START and STOP together in IDLE: START wins; then STOP aborts FILL
    @(negedge CLK);
    START = 1'b1; STOP = 1'b1;
    @(negedge CLK);
    START = 1'b0; STOP = 1'b0;
    chk("start_wins", busy, 1);
    @(negedge CLK) STOP = 1'b1;
    @(negedge CLK) STOP = 1'b0;
    chk("stop_fill", busy, 0);

    // 6: async reset mid-FILL and mid-COMPARE
    go(2'b00, 16'd100);
    while (cyc < 20) tick();
    #1 RST_N = 1'b0;
    #1;
    chk("t6_fill_shift_en", shift_en, 0);
    chk("t6_fill_busy", busy, 0);
    @(negedge CLK) RST_N = 1'b1;
    flt_en = 2'b01; flt_val = 2'b00;
    go(2'b00, 16'd100);
    while (cyc < 90) tick();
    chk("t6_mid_cnt", err_cnt[CW-1:0], 23);
    #1 RST_N = 1'b0;
    #1;
    chk("t6_cmp_cnt", err_cnt, 0);
    chk("t6_cmp_flag", err_flag, 0);
    chk("t6_cmp_shift_en", shift_en, 0);
    chk("t6_cmp_shift_in", shift_in, 0);
    @(negedge CLK) RST_N = 1'b1;
    flt_en = 2'b00;

    // START and new MODE/RUN_LEN while busy are ignored
    go(2'b00, 16'd100);
    while (cyc < 30) tick();
    MODE = 2'b10; RUN_LEN = 16'd5; START = 1'b1;
    tick();
    START = 1'b0;
    tick();
    chk("busy_start_pat", shift_in, 2'b11);
    wait_done(at);
    chk("busy_start_done", at, 167);
    chk("busy_start_cnt", err_cnt, 0);

    // RUN_LEN=0 runs until STOP
    go(2'b00, 16'd0);
    d0 = done_cnt;
    while (cyc < 400) tick();
    chk("free_busy", busy, 1);
    chk("free_no_done", done_cnt - d0, 0);
    STOP = 1'b1;
    tick();
    STOP = 1'b0;
    chk("free_stop", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
